// File: rtl/tank_pkg.sv
// Shared definitions for tank-game blocks: screen geometry, facing directions
// and shell engine states.
package tank_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int TANK_SIZE = 32;
    localparam int POS_W     = 11;

    typedef enum logic [2:0] {
        DIR_UP    = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLY      = 2'd1,
        ST_COOLDOWN = 2'd2
    } shell_state_e;

    function automatic logic dir_valid(input logic [2:0] d);
        return (d >= 3'd1) && (d <= 3'd4);
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned square overlap test between box A and box B,
// given their top-left corners; edges that merely touch do not overlap.
module box_overlap #(
    parameter int A_SIZE = 4,
    parameter int B_SIZE = 32,
    parameter int W      = 11
) (
    input  logic [W-1:0] a_x,
    input  logic [W-1:0] a_y,
    input  logic [W-1:0] b_x,
    input  logic [W-1:0] b_y,
    output logic         overlap
);

    localparam logic [W-1:0] A_S = W'(A_SIZE);
    localparam logic [W-1:0] B_S = W'(B_SIZE);

    assign overlap = (a_x < b_x + B_S) && (b_x < a_x + A_S) &&
                     (a_y < b_y + B_S) && (b_y < a_y + A_S);

endmodule

// File: rtl/tank_shell.sv
// Single-shell projectile engine for one tank: spawns at the muzzle, moves per
// frame tick, reports hit/miss and drives the per-pixel shell flag.
module tank_shell #(
    parameter int SHELL_SIZE      = 4,
    parameter int SPEED           = 4,
    parameter int TANK_SIZE       = tank_pkg::TANK_SIZE,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       fire_req,
    input  logic [9:0] tank_X,
    input  logic [9:0] tank_Y,
    input  logic [2:0] tank_dir,
    input  logic [9:0] target_X,
    input  logic [9:0] target_Y,
    input  logic       target_valid,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       fire_ack,
    output logic       busy,
    output logic [9:0] shell_X,
    output logic [9:0] shell_Y,
    output logic       hit,
    output logic       miss,
    output logic       is_shell
);

    import tank_pkg::*;

    localparam int CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] CD_L = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [POS_W-1:0] S_L   = POS_W'(SHELL_SIZE);
    localparam logic [POS_W-1:0] T_L   = POS_W'(TANK_SIZE);
    localparam logic [POS_W-1:0] C_L   = POS_W'((TANK_SIZE - SHELL_SIZE) / 2);
    localparam logic [POS_W-1:0] SPD_L = POS_W'(SPEED);
    localparam logic [POS_W-1:0] W_L   = POS_W'(SCREEN_W);
    localparam logic [POS_W-1:0] H_L   = POS_W'(SCREEN_H);

    shell_state_e     state_reg, state_next;
    dir_e             dir_reg, dir_next;
    logic [POS_W-1:0] sx_reg, sx_next, sy_reg, sy_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ack_reg, ack_next, hit_reg, hit_next, miss_reg, miss_next;

    logic [POS_W-1:0] tx, ty, spawn_x, spawn_y;
    logic             spawn_ok, edge_miss, tgt_overlap;

    assign tx = {1'b0, tank_X};
    assign ty = {1'b0, tank_Y};

    box_overlap #(
        .A_SIZE (SHELL_SIZE),
        .B_SIZE (TANK_SIZE),
        .W      (POS_W)
    ) u_target_overlap (
        .a_x     (sx_reg),
        .a_y     (sy_reg),
        .b_x     ({1'b0, target_X}),
        .b_y     ({1'b0, target_Y}),
        .overlap (tgt_overlap)
    );

    // Muzzle position; 11-bit sums never wrap for 10-bit inputs.
    always_comb begin
        spawn_x  = tx;
        spawn_y  = ty;
        spawn_ok = 1'b0;
        case (dir_e'(tank_dir))
            DIR_UP: begin
                spawn_x  = tx + C_L;
                spawn_y  = ty - S_L;
                spawn_ok = (ty >= S_L);
            end
            DIR_DOWN: begin
                spawn_x  = tx + C_L;
                spawn_y  = ty + T_L;
                spawn_ok = (ty + T_L + S_L <= H_L);
            end
            DIR_RIGHT: begin
                spawn_x  = tx + T_L;
                spawn_y  = ty + C_L;
                spawn_ok = (tx + T_L + S_L <= W_L);
            end
            DIR_LEFT: begin
                spawn_x  = tx - S_L;
                spawn_y  = ty + C_L;
                spawn_ok = (tx >= S_L);
            end
            default: spawn_ok = 1'b0;
        endcase
    end

    always_comb begin
        edge_miss = 1'b1;
        case (dir_reg)
            DIR_UP:    edge_miss = (sy_reg < SPD_L);
            DIR_DOWN:  edge_miss = (sy_reg + S_L + SPD_L > H_L);
            DIR_LEFT:  edge_miss = (sx_reg < SPD_L);
            DIR_RIGHT: edge_miss = (sx_reg + S_L + SPD_L > W_L);
            default:   edge_miss = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        sx_next    = sx_reg;
        sy_next    = sy_reg;
        cnt_next   = cnt_reg;
        ack_next   = 1'b0;
        hit_next   = 1'b0;
        miss_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (fire_req && dir_valid(tank_dir)) begin
                    ack_next = 1'b1;
                    if (spawn_ok) begin
                        state_next = ST_FLY;
                        dir_next   = dir_e'(tank_dir);
                        sx_next    = spawn_x;
                        sy_next    = spawn_y;
                    end else begin
                        miss_next  = 1'b1;
                        state_next = ST_COOLDOWN;
                        cnt_next   = CD_L;
                    end
                end
            end
            ST_FLY: begin
                // Hit is checked every clock and preempts the frame move.
                if (target_valid && tgt_overlap) begin
                    hit_next   = 1'b1;
                    state_next = ST_COOLDOWN;
                    cnt_next   = CD_L;
                end else if (frame_tick) begin
                    if (edge_miss) begin
                        miss_next  = 1'b1;
                        state_next = ST_COOLDOWN;
                        cnt_next   = CD_L;
                    end else begin
                        case (dir_reg)
                            DIR_UP:    sy_next = sy_reg - SPD_L;
                            DIR_DOWN:  sy_next = sy_reg + SPD_L;
                            DIR_LEFT:  sx_next = sx_reg - SPD_L;
                            DIR_RIGHT: sx_next = sx_reg + SPD_L;
                            default:   sx_next = sx_reg;
                        endcase
                    end
                end
            end
            ST_COOLDOWN: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else if (frame_tick) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg <= ST_IDLE;
            dir_reg   <= DIR_UP;
            sx_reg    <= '0;
            sy_reg    <= '0;
            cnt_reg   <= '0;
            ack_reg   <= 1'b0;
            hit_reg   <= 1'b0;
            miss_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            dir_reg   <= dir_next;
            sx_reg    <= sx_next;
            sy_reg    <= sy_next;
            cnt_reg   <= cnt_next;
            ack_reg   <= ack_next;
            hit_reg   <= hit_next;
            miss_reg  <= miss_next;
        end
    end

    assign fire_ack = ack_reg;
    assign hit      = hit_reg;
    assign miss     = miss_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign shell_X  = sx_reg[9:0];
    assign shell_Y  = sy_reg[9:0];

    assign is_shell = (state_reg == ST_FLY) &&
                      ({1'b0, DrawX} >= sx_reg) && ({1'b0, DrawX} < sx_reg + S_L) &&
                      ({1'b0, DrawY} >= sy_reg) && ({1'b0, DrawY} < sy_reg + S_L);

endmodule
